// File: rtl/graycode_pkg.sv
// Shared Gray-code helpers and the decoder FSM state type.
// Values are carried zero-extended in a 32-bit word, so any width up to 32 decodes correctly.
package graycode_pkg;

    typedef logic [31:0] gword_t;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } gcd_state_e;

    // Leading zeros decode to zeros, so a narrow code gives the same low bits as a native decoder.
    function automatic gword_t gray2bin(input gword_t g);
        gword_t b;
        b     = '0;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic gword_t bin2gray(input gword_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [5:0] popcount(input gword_t v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + 6'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/graycount_decoder_if.sv
// Signal bundle between the Gray pointer consumer and the local logic.
interface graycount_decoder_if #(
    parameter int COUNTER_WIDTH = 4
);
    logic [COUNTER_WIDTH-1:0] GrayCount_in;
    logic                     Clear_in;
    logic [COUNTER_WIDTH-1:0] BinaryCount_out;
    logic                     Advance_out;
    logic                     Valid_out;
    logic                     Error_out;

    modport master (
        output GrayCount_in, Clear_in,
        input  BinaryCount_out, Advance_out, Valid_out, Error_out
    );

    modport slave (
        input  GrayCount_in, Clear_in,
        output BinaryCount_out, Advance_out, Valid_out, Error_out
    );
endinterface

// File: rtl/gray_sync.sv
// Plain multi-flop synchronizer chain for a Gray-coded bus; no logic between stages.
module gray_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             Clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [STAGES-1:0][WIDTH-1:0] r_stage;

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage <= '0;
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/graycount_decoder.sv
// Consumer end of a Gray pointer crossing: sync, decode, and police single-step forward advances.
//   state | meaning
//   FILL  | synchronizer filling after reset; outputs held low
//   TRACK | checking each new sample; legal +1 steps pulse Advance_out
//   FAULT | illegal change seen; count still tracks, advances suppressed until Clear_in
module graycount_decoder
    import graycode_pkg::*;
#(
    parameter int COUNTER_WIDTH = 4,
    parameter int SYNC_STAGES   = 2
) (
    input logic                Clk,
    input logic                rst_n,
    graycount_decoder_if.slave bus
);

    localparam int     CW   = $clog2(SYNC_STAGES + 1);
    localparam gword_t MASK = {32{1'b1}} >> (32 - COUNTER_WIDTH);

    logic [COUNTER_WIDTH-1:0] w_g;
    gword_t                   w_g_ext;
    gword_t                   w_bin_ext;
    gword_t                   w_delta;
    logic [5:0]               w_hd;
    logic                     w_legal;
    logic                     w_illegal;

    gcd_state_e               r_state;
    logic [CW-1:0]            r_fill_cnt;
    gword_t                   r_gray_q;
    gword_t                   r_bin_q;
    logic                     r_adv;
    logic                     r_valid;
    logic                     r_err;

    gray_sync #(
        .WIDTH  (COUNTER_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .Clk   (Clk),
        .rst_n (rst_n),
        .i_d   (bus.GrayCount_in),
        .o_q   (w_g)
    );

    always_comb begin
        w_g_ext                    = '0;
        w_g_ext[COUNTER_WIDTH-1:0] = w_g;
    end

    // The previous sample is always last cycle's, so a Clear re-base falls out naturally.
    assign w_bin_ext = gray2bin(w_g_ext);
    assign w_hd      = popcount(w_g_ext ^ r_gray_q);
    assign w_delta   = (w_bin_ext - r_bin_q) & MASK;
    assign w_legal   = (w_hd == 6'd1) && (w_delta == 32'd1);
    assign w_illegal = (w_hd != 6'd0) && !w_legal;

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FILL;
            r_fill_cnt <= CW'(SYNC_STAGES);
            r_gray_q   <= '0;
            r_bin_q    <= '0;
            r_adv      <= 1'b0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_gray_q <= w_g_ext;
            r_bin_q  <= w_bin_ext;
            r_adv    <= 1'b0;
            case (r_state)
                FILL: begin
                    if (r_fill_cnt != '0) begin
                        r_fill_cnt <= r_fill_cnt - CW'(1);
                        r_bin_q    <= '0;
                    end else begin
                        r_state <= TRACK;
                        r_valid <= 1'b1;
                    end
                end
                TRACK: begin
                    if (w_legal) begin
                        r_adv <= 1'b1;
                    end else if (w_illegal) begin
                        r_err   <= 1'b1;
                        r_state <= FAULT;
                    end
                end
                FAULT: begin
                    if (bus.Clear_in) begin
                        r_err   <= 1'b0;
                        r_state <= TRACK;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    assign bus.BinaryCount_out = r_bin_q[COUNTER_WIDTH-1:0];
    assign bus.Advance_out     = r_adv;
    assign bus.Valid_out       = r_valid;
    assign bus.Error_out       = r_err;

endmodule

// File: tb/tb_graycount_decoder.sv
// Self-checking bench for graycount_decoder (W=4, S=2) using a latency-aligned scoreboard.
module tb_graycount_decoder;

    localparam int NONE = 0;
    localparam int LEG  = 1;
    localparam int ILL  = 2;

    typedef struct {
        logic [3:0] bin;
        int         cls;
    } sb_t;

    typedef struct {
        bit         rst;
        logic [3:0] gray;
        logic       clr;
        int         hold;
        logic [3:0] bin;
        int         cls;
    } vec_t;

    logic Clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   adv_cnt;
    bit   m_first;
    bit   m_fault;
    logic last_clr;
    sb_t  sb[$];
    vec_t vt[16];

    graycount_decoder_if #(.COUNTER_WIDTH(4)) bus ();

    graycount_decoder #(
        .COUNTER_WIDTH (4),
        .SYNC_STAGES   (2)
    ) dut (
        .Clk   (Clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Once three samples are in flight, the oldest is the one now on the outputs.
    task automatic check_out();
        sb_t        e;
        logic [3:0] eb;
        logic       ea;
        logic       ev;
        logic       ee;
        eb = '0; ea = 1'b0; ev = 1'b0; ee = 1'b0;
        if (sb.size() == 3) begin
            e  = sb.pop_front();
            eb = e.bin;
            ev = 1'b1;
            if (m_first) begin
                m_first = 1'b0;
            end else if (m_fault) begin
                if (last_clr) m_fault = 1'b0;
            end else if (e.cls == LEG) begin
                ea = 1'b1;
            end else if (e.cls == ILL) begin
                m_fault = 1'b1;
            end
            ee = m_fault;
        end
        chk("bin",   32'(bus.BinaryCount_out), 32'(eb));
        chk("adv",   32'(bus.Advance_out),     32'(ea));
        chk("valid", 32'(bus.Valid_out),       32'(ev));
        chk("err",   32'(bus.Error_out),       32'(ee));
        if (bus.Advance_out === 1'b1) adv_cnt++;
    endtask

    task automatic step(input logic [3:0] g, input logic c, input int cls, input logic [3:0] b);
        bus.GrayCount_in = g;
        bus.Clear_in     = c;
        last_clr         = c;
        sb.push_back('{bin: b, cls: cls});
        @(negedge Clk);
        check_out();
    endtask

    task automatic run_gray(input logic [3:0] g, input logic c, input int hold, input int cls,
                            input logic [3:0] b);
        for (int i = 0; i < hold; i++) begin
            step(g, (i == 0) ? c : 1'b0, (i == 0) ? cls : NONE, b);
        end
    endtask

    task automatic run_bin(input logic [3:0] b, input int hold, input int cls);
        logic [3:0] g;
        g = b ^ (b >> 1);
        run_gray(g, 1'b0, hold, cls, b);
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        bus.GrayCount_in = '0;
        bus.Clear_in     = 1'b0;
        last_clr         = 1'b0;
        sb.delete();
        m_first          = 1'b1;
        m_fault          = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            check_out();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        adv_cnt = 0;

        vt[0]  = '{1, 4'b0000, 1'b0, 4, 4'd0, NONE};
        vt[1]  = '{0, 4'b0001, 1'b0, 4, 4'd1, LEG};
        vt[2]  = '{0, 4'b0011, 1'b0, 4, 4'd2, LEG};
        vt[3]  = '{0, 4'b0101, 1'b0, 4, 4'd6, ILL};
        vt[4]  = '{0, 4'b0100, 1'b0, 4, 4'd7, LEG};
        vt[5]  = '{0, 4'b1100, 1'b0, 4, 4'd8, LEG};
        vt[6]  = '{1, 4'b0000, 1'b0, 4, 4'd0, NONE};
        vt[7]  = '{0, 4'b0001, 1'b0, 4, 4'd1, LEG};
        vt[8]  = '{0, 4'b0011, 1'b0, 4, 4'd2, LEG};
        vt[9]  = '{0, 4'b0001, 1'b0, 4, 4'd1, ILL};
        vt[10] = '{0, 4'b0001, 1'b1, 4, 4'd1, NONE};
        vt[11] = '{0, 4'b0011, 1'b0, 4, 4'd2, LEG};
        vt[12] = '{0, 4'b0000, 1'b0, 4, 4'd0, ILL};
        vt[13] = '{0, 4'b0110, 1'b0, 2, 4'd4, ILL};
        vt[14] = '{0, 4'b0110, 1'b1, 4, 4'd4, NONE};
        vt[15] = '{0, 4'b0111, 1'b0, 4, 4'd5, LEG};

        // Reset, fill, then full forward sweep including the 15 -> 0 wrap.
        do_reset();
        run_bin(4'd0, 4, NONE);
        adv_cnt = 0;
        for (int i = 1; i <= 16; i++) run_bin(4'(i), 4, LEG);
        chk("sweep_adv_count", 32'(adv_cnt), 32'd16);

        // One step per cycle.
        adv_cnt = 0;
        for (int i = 1; i <= 20; i++) run_bin(4'(i), 1, LEG);
        run_bin(4'd4, 3, NONE);
        chk("b2b_adv_count", 32'(adv_cnt), 32'd20);

        // Jumps, backward step, clear, and clear colliding with an illegal change.
        for (int r = 0; r < 16; r++) begin
            if (vt[r].rst) do_reset();
            run_gray(vt[r].gray, vt[r].clr, vt[r].hold, vt[r].cls, vt[r].bin);
        end

        // Fault, then asynchronous reset between edges.
        run_gray(4'b0000, 1'b0, 4, ILL, 4'd0);
        chk("err_before_rst", 32'(bus.Error_out), 32'd1);
        @(posedge Clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_err",   32'(bus.Error_out),       32'd0);
        chk("async_rst_valid", 32'(bus.Valid_out),       32'd0);
        chk("async_rst_adv",   32'(bus.Advance_out),     32'd0);
        chk("async_rst_bin",   32'(bus.BinaryCount_out), 32'd0);
        do_reset();
        run_bin(4'd0, 6, NONE);
        adv_cnt = 0;
        run_bin(4'd1, 4, LEG);
        chk("post_rst_adv_count", 32'(adv_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
